fp_sgnj_pipe: RTL

- Pipelined, parametrised floating-point sign-injection unit for the FP_Unit.
- Performs SGNJ, SGNJN and SGNJX, plus a pass-through move, on single- or double-precision operands.
- Checks RISC-V NaN-boxing of single-precision inputs.
- Uses a valid/ready handshake with configurable depth and carries a writeback tag alongside the data, so it can sit beside the other FP execution pipes.

---
 rtl/fp_sgnj_pkg.sv | 26 ++
 rtl/fp_sgnj_core.sv | 46 ++++
 rtl/fp_sgnj_pipe.sv | 84 ++++++++
 3 files changed

// File: rtl/fp_sgnj_pkg.sv
// Shared constants and helpers for the floating-point sign-injection unit.
package fp_sgnj_pkg;

    localparam logic [1:0] JNX_SGNJ  = 2'd0;
    localparam logic [1:0] JNX_SGNJN = 2'd1;
    localparam logic [1:0] JNX_SGNJX = 2'd2;
    localparam logic [1:0] JNX_MOVE  = 2'd3;

    localparam logic [31:0] SP_CANON_NAN = 32'h7FC0_0000;
    localparam logic [31:0] NANBOX_HI    = 32'hFFFF_FFFF;

    // Result sign for a given mode; MOVE keeps the sign of A.
    function automatic logic sel_sign(input logic [1:0] mode,
                                      input logic       sign_a,
                                      input logic       sign_b);
        logic s;
        case (mode)
            JNX_SGNJ:  s = sign_b;
            JNX_SGNJN: s = ~sign_b;
            JNX_SGNJX: s = sign_a ^ sign_b;
            default:   s = sign_a;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/fp_sgnj_core.sv
// Combinational sign injection with RISC-V NaN-box checking of SP operands.
module fp_sgnj_core
    import fp_sgnj_pkg::*;
#(
    parameter int unsigned FLEN       = 64,
    parameter int unsigned NANBOX_CHK = 1
) (
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    input  logic [1:0]      mode,
    input  logic            fmt,
    output logic [FLEN-1:0] result
);

    localparam bit HAS_DP = (FLEN == 64);
    localparam bit CHK_EN = (NANBOX_CHK != 0) && HAS_DP;

    logic [63:0] a_w;
    logic [63:0] b_w;
    logic [31:0] a_sp;
    logic        b_sp_sign;
    logic        is_dp;
    logic        sign_a;
    logic        sign_b;
    logic        sign_r;
    logic [63:0] res_w;
    logic        unused_b_mag;

    // Only the sign of B matters; its magnitude bits are intentionally dropped.
    assign unused_b_mag = ^b_w[30:0];

    // Unbox, pick the sign, and rebuild the result (FLEN=32 keeps the low word).
    always_comb begin
        a_w    = 64'(a);
        b_w    = 64'(b);
        is_dp  = HAS_DP && fmt;
        a_sp   = (CHK_EN && (a_w[63:32] != NANBOX_HI)) ? SP_CANON_NAN : a_w[31:0];
        b_sp_sign = (CHK_EN && (b_w[63:32] != NANBOX_HI)) ? SP_CANON_NAN[31] : b_w[31];
        sign_a = is_dp ? a_w[63] : a_sp[31];
        sign_b = is_dp ? b_w[63] : b_sp_sign;
        sign_r = sel_sign(mode, sign_a, sign_b);
        res_w  = is_dp ? {sign_r, a_w[62:0]} : {NANBOX_HI, sign_r, a_sp[30:0]};
        result = FLEN'(res_w);
    end

endmodule

// File: rtl/fp_sgnj_pipe.sv
// Pipelined sign-injection unit: core datapath followed by a valid/ready stage chain.
module fp_sgnj_pipe
    import fp_sgnj_pkg::*;
#(
    parameter int unsigned FLEN       = 64,
    parameter int unsigned STAGES     = 2,
    parameter int unsigned TAG_W      = 5,
    parameter int unsigned NANBOX_CHK = 1
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_valid,
    output logic             out_ready_in,
    input  logic [FLEN-1:0]  in_numA,
    input  logic [FLEN-1:0]  in_numB,
    input  logic [1:0]       in_ctrl_jnx,
    input  logic             in_fmt,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_flush,
    output logic             out_valid,
    input  logic             in_ready_out,
    output logic [FLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag
);

    logic [FLEN-1:0]                core_res;
    logic [STAGES-1:0]              ready_c;
    logic [STAGES-1:0]              valid_q;
    logic [STAGES-1:0][FLEN-1:0]    data_q;
    logic [STAGES-1:0][TAG_W-1:0]   tag_q;
    logic [STAGES-1:0]              up_valid;
    logic [STAGES-1:0][FLEN-1:0]    up_data;
    logic [STAGES-1:0][TAG_W-1:0]   up_tag;

    fp_sgnj_core #(
        .FLEN       (FLEN),
        .NANBOX_CHK (NANBOX_CHK)
    ) u_core (
        .a      (in_numA),
        .b      (in_numB),
        .mode   (in_ctrl_jnx),
        .fmt    (in_fmt),
        .result (core_res)
    );

    // A stage can load unless it and every stage after it are full and the sink stalls.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        assign ready_c[i] = in_ready_out | ~(&valid_q[STAGES-1:i]);
        if (i == 0) begin : g_head
            assign up_valid[i] = in_valid;
            assign up_data[i]  = core_res;
            assign up_tag[i]   = in_tag;
        end else begin : g_body
            assign up_valid[i] = valid_q[i-1];
            assign up_data[i]  = data_q[i-1];
            assign up_tag[i]   = tag_q[i-1];
        end
    end

    // Stage registers: reset clears all, flush kills valids, otherwise shift where ready.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            valid_q <= '0;
            data_q  <= '0;
            tag_q   <= '0;
        end else if (in_flush) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (ready_c[i]) begin
                    valid_q[i] <= up_valid[i];
                    data_q[i]  <= up_data[i];
                    tag_q[i]   <= up_tag[i];
                end
            end
        end
    end

    assign out_ready_in = ready_c[0];
    assign out_valid    = valid_q[STAGES-1];
    assign out_data     = data_q[STAGES-1];
    assign out_tag      = tag_q[STAGES-1];

endmodule
